// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter: FSM state encoding,
// transaction owner encoding and a constant-evaluable log2 helper.
package mem_arb_pkg;

    // Arbiter sequencing states; one memory transaction in flight at a time.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_WAIT = 2'd2,
        WR_DATA = 2'd3
    } arb_state_e;

    // Which cache owns the transaction currently being sequenced.
    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    // Ceiling log2, used for the beat counter and line-offset widths.
    // Returns at least 1 so derived vectors never collapse to zero width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Grant picker for the memory arbiter. Decides which cache's pending request
// is accepted while the arbiter is idle and keeps the fairness state.
// Build option: MEM_ARB_RR_EN selects round-robin instead of dc-priority with
// a starvation guard for the icache.
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ic_valid,
    input  logic dc_valid,
    input  logic idle,
    output logic grant_ic,
    output logic grant_dc
);

`ifdef MEM_ARB_RR_EN

    owner_e last_owner;

    // Round-robin grant: on contention the last-granted owner loses.
    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (idle) begin
            if (ic_valid && dc_valid) begin
                grant_dc = (last_owner == OWN_IC);
                grant_ic = !grant_dc;
            end else begin
                grant_ic = ic_valid;
                grant_dc = dc_valid;
            end
        end
    end

    // Remember the last winner; resetting to icache lets dcache win the first tie.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_IC;
        end else if (grant_ic) begin
            last_owner <= OWN_IC;
        end else if (grant_dc) begin
            last_owner <= OWN_DC;
        end
    end

`else

    localparam int CNT_W = clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    // Dcache-priority grant, overridden for the icache once it has waited long enough.
    always_comb begin
        starved  = (starve_cnt == CNT_MAX);
        grant_ic = idle && ic_valid && (!dc_valid || starved);
        grant_dc = idle && dc_valid && !grant_ic;
    end

    // Count dcache wins while the icache is waiting; saturate at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_ic || !ic_valid) begin
            starve_cnt <= '0;
        end else if (grant_dc && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter shared by the icache and dcache. Accepts one request at a
// time, issues it to memory with a rolling tag, then either collects the read
// beats for the owning cache or streams the dcache writeback beats.
// Build option: MEM_ARB_RR_EN (round-robin grant, see mem_arb_picker).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 128,
    parameter int BEATS      = 4,
    parameter int TAG_W      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    // icache refill requests
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic              ic_resp_last,
    // dcache refill / writeback requests
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic              dc_req_rnw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic              dc_resp_last,
    // refill data shared by both caches
    output logic [DATA_W-1:0] resp_data,
    // memory port
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [TAG_W-1:0]  mem_req_tag,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [TAG_W-1:0]  mem_resp_tag,
    input  logic [DATA_W-1:0] mem_resp_data,
    // status
    output logic              arb_busy,
    output logic              arb_err
);

    localparam int BEAT_W = clog2(BEATS);
    localparam int OFF_W  = clog2(BEATS * DATA_W / 8);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);

    arb_state_e        state;
    arb_state_e        state_next;
    owner_e            owner_q;
    logic              rnw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  txn_tag;
    logic [BEAT_W-1:0] beat_q;

    logic idle;
    logic grant_ic;
    logic grant_dc;
    logic req_fire;
    logic rd_beat;
    logic wr_beat;
    logic last_beat;

    // Ready is offered only while idle and never while reset is held.
    assign idle      = (state == IDLE) && reset;
    assign req_fire  = (state == REQ) && mem_req_ready;
    assign rd_beat   = (state == RD_WAIT) && mem_resp_valid && (mem_resp_tag == txn_tag);
    assign wr_beat   = (state == WR_DATA) && mem_wready;
    assign last_beat = (beat_q == BEAT_LAST);

    assign mem_req_rnw  = rnw_q;
    assign mem_req_addr = addr_q;
    assign mem_req_tag  = tag_q;

    mem_arb_picker #(
        .STARVE_MAX (STARVE_MAX)
    ) u_picker (
        .clk      (clk),
        .reset    (reset),
        .ic_valid (ic_req_valid),
        .dc_valid (dc_req_valid),
        .idle     (idle),
        .grant_ic (grant_ic),
        .grant_dc (grant_dc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the handshake outputs that depend on the state.
    always_comb begin
        state_next     = state;
        ic_req_ready   = grant_ic;
        dc_req_ready   = grant_dc;
        mem_req_valid  = 1'b0;
        mem_wvalid     = 1'b0;
        dc_wdata_ready = 1'b0;
        mem_wdata      = '0;
        arb_busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_ic || grant_dc) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = rnw_q ? RD_WAIT : WR_DATA;
                end
            end
            RD_WAIT: begin
                if (rd_beat && last_beat) begin
                    state_next = IDLE;
                end
            end
            WR_DATA: begin
                mem_wvalid     = 1'b1;
                dc_wdata_ready = mem_wready;
                mem_wdata      = dc_wdata;
                if (mem_wready && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the accepted request, advance the tag on each memory handshake,
    // and count data beats (the counter wraps to 0 after the final beat).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_IC;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
            txn_tag <= '0;
            beat_q  <= '0;
        end else begin
            if (grant_dc) begin
                owner_q <= OWN_DC;
                rnw_q   <= dc_req_rnw;
                addr_q  <= dc_req_addr & ~OFF_MASK;
            end else if (grant_ic) begin
                owner_q <= OWN_IC;
                rnw_q   <= 1'b1;
                addr_q  <= ic_req_addr & ~OFF_MASK;
            end
            if (req_fire) begin
                txn_tag <= tag_q;
                tag_q   <= tag_q + TAG_W'(1);
            end
            if (rd_beat || wr_beat) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Register matching read beats and steer them to the owning cache only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ic_resp_valid <= 1'b0;
            ic_resp_last  <= 1'b0;
            dc_resp_valid <= 1'b0;
            dc_resp_last  <= 1'b0;
            resp_data     <= '0;
        end else begin
            ic_resp_valid <= rd_beat && (owner_q == OWN_IC);
            ic_resp_last  <= rd_beat && (owner_q == OWN_IC) && last_beat;
            dc_resp_valid <= rd_beat && (owner_q == OWN_DC);
            dc_resp_last  <= rd_beat && (owner_q == OWN_DC) && last_beat;
            if (rd_beat) begin
                resp_data <= mem_resp_data;
            end
        end
    end

    // Sticky error: any memory beat that is not a matching beat in RD_WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_err <= 1'b0;
        end else if (mem_resp_valid && !rd_beat) begin
            arb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for write backpressure, tag wrap, bad-tag beats,
// mid-transfer reset and grant fairness. Read beats are checked against a
// scoreboard queue filled when the memory beats are driven.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic              ic_resp_last;
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rnw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_wdata_ready;
    logic              dc_resp_valid;
    logic              dc_resp_last;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rnw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [TAG_W-1:0]  mem_req_tag;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [TAG_W-1:0]  mem_resp_tag;
    logic [DATA_W-1:0] mem_resp_data;
    logic              arb_busy;
    logic              arb_err;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BEATS      (BEATS),
        .TAG_W      (TAG_W),
        .STARVE_MAX (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req_valid   (ic_req_valid),
        .ic_req_ready   (ic_req_ready),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_last   (ic_resp_last),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_rnw     (dc_req_rnw),
        .dc_req_addr    (dc_req_addr),
        .dc_wdata       (dc_wdata),
        .dc_wdata_ready (dc_wdata_ready),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_last   (dc_resp_last),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rnw    (mem_req_rnw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_tag    (mem_req_tag),
        .mem_wvalid     (mem_wvalid),
        .mem_wready     (mem_wready),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_tag   (mem_resp_tag),
        .mem_resp_data  (mem_resp_data),
        .arb_busy       (arb_busy),
        .arb_err        (arb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [TAG_W-1:0] model_tag;

    typedef struct {
        bit                dc;
        logic [DATA_W-1:0] data;
        bit                last;
        int                cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        bit                dc;
        bit                rnw;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] exp_addr;
        int                stall;
    } vec_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every refill beat must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ic_resp_valid || dc_resp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got ic=%0b dc=%0b, expected no beat", ic_resp_valid, dc_resp_valid);
            end else begin
                e = sb.pop_front();
                check("resp_valid_dc", dc_resp_valid, e.dc);
                check("resp_valid_ic", ic_resp_valid, !e.dc);
                check("resp_data", resp_data, e.data);
                check("resp_last", e.dc ? dc_resp_last : ic_resp_last, e.last);
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ic_req_ready"},   ic_req_ready,   0);
        check({tag, "_dc_req_ready"},   dc_req_ready,   0);
        check({tag, "_ic_resp_valid"},  ic_resp_valid,  0);
        check({tag, "_ic_resp_last"},   ic_resp_last,   0);
        check({tag, "_dc_resp_valid"},  dc_resp_valid,  0);
        check({tag, "_dc_resp_last"},   dc_resp_last,   0);
        check({tag, "_dc_wdata_ready"}, dc_wdata_ready, 0);
        check({tag, "_resp_data"},      resp_data,      0);
        check({tag, "_mem_req_valid"},  mem_req_valid,  0);
        check({tag, "_mem_req_rnw"},    mem_req_rnw,    0);
        check({tag, "_mem_req_addr"},   mem_req_addr,   0);
        check({tag, "_mem_req_tag"},    mem_req_tag,    0);
        check({tag, "_mem_wvalid"},     mem_wvalid,     0);
        check({tag, "_mem_wdata"},      mem_wdata,      0);
        check({tag, "_arb_busy"},       arb_busy,       0);
        check({tag, "_arb_err"},        arb_err,        0);
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        ic_req_valid   = 1'b0;
        dc_req_valid   = 1'b0;
        mem_resp_valid = 1'b0;
        mem_wready     = 1'b0;
        mem_req_ready  = 1'b0;
        sb.delete();
        model_tag = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, arb_busy, 0);
        tick();
    endtask

    // Wait (bounded) for either ready; called just after a rising edge.
    task automatic wait_grant(output bit got_ic, output bit got_dc, output bit ok);
        int n;
        ok = 0;
        got_ic = 0;
        got_dc = 0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (ic_req_ready || dc_req_ready) begin
                ok = 1;
                got_ic = ic_req_ready;
                got_dc = dc_req_ready;
            end else begin
                tick();
            end
            n++;
        end
        check("grant_seen", ok, 1);
    endtask

    // REQ phase: memory stalls for 'stall' cycles, request must stay stable.
    task automatic req_phase(input bit rnw, input logic [ADDR_W-1:0] exp_addr, input int stall,
                             output logic [TAG_W-1:0] tag);
        tag = model_tag;
        mem_req_ready = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) mem_req_ready = 1'b1;
            @(negedge clk);
            check("mem_req_valid", mem_req_valid, 1);
            check("mem_req_addr", mem_req_addr, exp_addr);
            check("mem_req_rnw", mem_req_rnw, rnw);
            check("mem_req_tag", mem_req_tag, model_tag);
            check("ready_outside_idle", ic_req_ready | dc_req_ready, 0);
            check("busy_in_req", arb_busy, 1);
            tick();
        end
        model_tag = model_tag + 1'b1;
    endtask

    task automatic issue(input bit dc, input bit rnw, input logic [ADDR_W-1:0] addr,
                         input logic [ADDR_W-1:0] exp_addr, input int stall,
                         output logic [TAG_W-1:0] tag);
        bit gi, gd, ok;
        if (dc) begin
            dc_req_valid = 1'b1;
            dc_req_rnw   = rnw;
            dc_req_addr  = addr;
        end else begin
            ic_req_valid = 1'b1;
            ic_req_addr  = addr;
        end
        wait_grant(gi, gd, ok);
        check(dc ? "dc_grant" : "ic_grant", dc ? gd : gi, 1);
        tick();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        req_phase(rnw, exp_addr, stall, tag);
    endtask

    // Drive n good beats (optionally a wrong-tag beat before index bad_at).
    task automatic read_beats(input bit dc, input logic [TAG_W-1:0] tag, input int bad_at, input int n);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            if (b == bad_at) begin
                mem_resp_valid = 1'b1;
                mem_resp_tag   = tag + 4'd3;
                mem_resp_data  = rnd_beat();
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_tag   = tag;
            mem_resp_data  = rnd_beat();
            e.dc   = dc;
            e.data = mem_resp_data;
            e.last = (b == BEATS - 1);
            e.cyc  = cyc + 1;
            sb.push_back(e);
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

    // Stream writeback beats with mem_wready following pat (LSB first).
    task automatic write_beats(input logic [7:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            mem_wready = pat[i];
            dc_wdata   = rnd_beat();
            @(negedge clk);
            check("mem_wvalid", mem_wvalid, 1);
            check("dc_wdata_ready", dc_wdata_ready, pat[i]);
            check("mem_wdata", mem_wdata, dc_wdata);
            tick();
        end
        mem_wready = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[6];
        logic [TAG_W-1:0] t;
        bit exp_dc[4];
        int n_grants;
        bit gi, gd, ok;

        vecs[0] = '{dc: 0, rnw: 1, addr: 32'h0000_0100, exp_addr: 32'h0000_0100, stall: 0};
        vecs[1] = '{dc: 1, rnw: 1, addr: 32'h0000_1234, exp_addr: 32'h0000_1200, stall: 2};
        vecs[2] = '{dc: 1, rnw: 0, addr: 32'h0000_2000, exp_addr: 32'h0000_2000, stall: 0};
        vecs[3] = '{dc: 0, rnw: 1, addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFC0, stall: 1};
        vecs[4] = '{dc: 1, rnw: 0, addr: 32'h0000_003F, exp_addr: 32'h0000_0000, stall: 3};
        vecs[5] = '{dc: 1, rnw: 1, addr: 32'hABCD_EF40, exp_addr: 32'hABCD_EF40, stall: 0};

        // Reset with both requests raised: everything must still read 0.
        reset          = 1'b0;
        ic_req_valid   = 1'b1;
        dc_req_valid   = 1'b1;
        dc_req_rnw     = 1'b1;
        ic_req_addr    = 32'h40;
        dc_req_addr    = 32'h80;
        dc_wdata       = rnd_beat();
        mem_req_ready  = 1'b0;
        mem_wready     = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_tag   = '0;
        mem_resp_data  = '0;
        model_tag      = '0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        mem_wready   = 1'b0;
        reset        = 1'b1;
        tick();

        // Table of single transactions.
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].dc, vecs[i].rnw, vecs[i].addr, vecs[i].exp_addr, vecs[i].stall, t);
            if (vecs[i].rnw) read_beats(vecs[i].dc, t, -1, BEATS);
            else write_beats(8'h0F, 4);
            check_idle("idle_after_vec");
        end

        // Writeback with memory backpressure 1,0,1,1,1.
        issue(1, 0, 32'h2000, 32'h2000, 0, t);
        write_beats(8'b0001_1101, 5);
        @(negedge clk);
        check("wr_idle_after_4th", arb_busy, 0);
        check("wr_no_5th_ready", dc_wdata_ready, 0);
        check("wr_no_wvalid", mem_wvalid, 0);
        tick();

        // 17 back-to-back reads: tag sequence 0..15 then wraps to 0.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            issue(0, 1, ADDR_W'(i * 64), ADDR_W'(i * 64), 0, t);
            read_beats(0, t, -1, BEATS);
        end
        check("tag_wrapped_to_1", mem_req_tag, 1);
        check("no_err_after_17", arb_err, 0);
        check_idle("idle_after_17");

        // Wrong-tag beat mid refill: dropped, error sticks, 4 good beats still complete.
        issue(1, 1, 32'h3000, 32'h3000, 0, t);
        read_beats(1, t, 1, BEATS);
        @(negedge clk);
        check("bad_tag_err", arb_err, 1);
        check("bad_tag_idle", arb_busy, 0);
        tick();
        issue(0, 1, 32'h3040, 32'h3040, 0, t);
        read_beats(0, t, -1, BEATS);
        @(negedge clk);
        check("err_sticky", arb_err, 1);
        tick();

        // Reset after two read beats: outputs drop at once, next request uses tag 0.
        issue(0, 1, 32'h5000, 32'h5000, 0, t);
        read_beats(0, t, -1, 2);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        sb.delete();
        model_tag = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        issue(0, 1, 32'h5100, 32'h5100, 0, t);
        read_beats(0, t, -1, BEATS);
        check_idle("idle_after_midreset");
        check("no_err_after_reset", arb_err, 0);

        // A memory beat while idle is an error.
        mem_resp_valid = 1'b1;
        mem_resp_tag   = model_tag;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("idle_beat_err", arb_err, 1);
        check("idle_beat_no_resp", ic_resp_valid | dc_resp_valid, 0);
        tick();

        // Simultaneous requests with dc re-requesting: fairness order.
`ifdef MEM_ARB_RR_EN
        exp_dc   = '{1, 0, 1, 0};
        n_grants = 3;
`else
        exp_dc   = '{1, 1, 1, 0};
        n_grants = 4;
`endif
        apply_reset();
        mem_req_ready = 1'b1;
        ic_req_valid  = 1'b1;
        ic_req_addr   = 32'h4000;
        dc_req_valid  = 1'b1;
        dc_req_rnw    = 1'b1;
        dc_req_addr   = 32'h8000;
        for (int g = 0; g < n_grants; g++) begin
            wait_grant(gi, gd, ok);
            check("fair_grant_dc", gd, exp_dc[g]);
            check("fair_grant_ic", gi, !exp_dc[g]);
            tick();
            if (gi) ic_req_valid = 1'b0;
            if (g == n_grants - 1) begin
                ic_req_valid = 1'b0;
                dc_req_valid = 1'b0;
            end
            req_phase(1, gd ? 32'h8000 : 32'h4000, 0, t);
            read_beats(gd, t, -1, BEATS);
        end
        check_idle("idle_after_fair");
        check("fair_no_err", arb_err, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
